// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and constants for the time-to-token processor array.
//   instr_e      - programming opcodes
//   SS_*         - {start,stop} event encodings reported on token_startstop
//   proc_state_t - per-processor dynamic state (token counters, countdown, active flag)
package ttt_pkg;

  localparam int PKG_TOKEN_BITS    = 8;
  localparam int PKG_DURATION_BITS = 8;

  typedef enum logic [2:0] {
    INSTR_NOP            = 3'b000,
    INSTR_LOAD_THRESHOLD = 3'b001,
    INSTR_LOAD_DURATION  = 3'b010,
    INSTR_CLEAR_STATE    = 3'b011,
    INSTR_CLEAR_ALL      = 3'b100
  } instr_e;

  localparam logic [1:0] SS_NONE  = 2'b00;
  localparam logic [1:0] SS_STOP  = 2'b01;
  localparam logic [1:0] SS_START = 2'b10;
  localparam logic [1:0] SS_BOTH  = 2'b11;

  typedef struct packed {
    logic [PKG_TOKEN_BITS-1:0]    good;
    logic [PKG_TOKEN_BITS-1:0]    bad;
    logic [PKG_DURATION_BITS-1:0] remaining;
    logic                         active;
  } proc_state_t;

endpackage

// File: rtl/ttt_proc_update.sv
// ttt_proc_update: combinational next-state and event logic for one processor visit.
//   cur_state       in   current good/bad/remaining/active of the visited processor
//   new_good_tokens in   good tokens arriving on this visit
//   new_bad_tokens  in   bad tokens arriving on this visit
//   threshold       in   net-token threshold for a start
//   duration        in   programmed start-to-stop duration (in visits)
//   next_state      out  state to store after the visit
//   startstop       out  {start,stop} event produced by the visit
module ttt_proc_update
  import ttt_pkg::*;
#(
  parameter int NEW_TOKEN_BITS = 8
) (
  input  proc_state_t                  cur_state,
  input  logic [NEW_TOKEN_BITS-1:0]    new_good_tokens,
  input  logic [NEW_TOKEN_BITS-1:0]    new_bad_tokens,
  input  logic [PKG_TOKEN_BITS-1:0]    threshold,
  input  logic [PKG_DURATION_BITS-1:0] duration,
  output proc_state_t                  next_state,
  output logic [1:0]                   startstop
);

  // One extra bit over the wider operand catches any carry out of the stored width.
  localparam int SUM_W = ((PKG_TOKEN_BITS > NEW_TOKEN_BITS) ? PKG_TOKEN_BITS : NEW_TOKEN_BITS) + 1;

  logic [SUM_W-1:0]          good_sum;
  logic [SUM_W-1:0]          bad_sum;
  logic [PKG_TOKEN_BITS-1:0] good_sat;
  logic [PKG_TOKEN_BITS-1:0] bad_sat;

  assign good_sum = SUM_W'(cur_state.good) + SUM_W'(new_good_tokens);
  assign bad_sum  = SUM_W'(cur_state.bad)  + SUM_W'(new_bad_tokens);

  // Saturate rather than wrap: any bit above the stored width means overflow.
  assign good_sat = (|good_sum[SUM_W-1:PKG_TOKEN_BITS]) ? '1 : good_sum[PKG_TOKEN_BITS-1:0];
  assign bad_sat  = (|bad_sum[SUM_W-1:PKG_TOKEN_BITS])  ? '1 : bad_sum[PKG_TOKEN_BITS-1:0];

  always_comb begin
    next_state      = cur_state;
    next_state.good = good_sat;
    next_state.bad  = bad_sat;
    startstop       = SS_NONE;

    if (cur_state.active) begin
      // Counting down; the start condition is not re-evaluated while active.
      if (cur_state.remaining <= PKG_DURATION_BITS'(1)) begin
        next_state.remaining = '0;
        next_state.active    = 1'b0;
        startstop            = SS_STOP;
      end else begin
        next_state.remaining = cur_state.remaining - PKG_DURATION_BITS'(1);
      end
    end else if ((good_sat > bad_sat) && ((good_sat - bad_sat) >= threshold)) begin
      next_state.good = '0;
      next_state.bad  = '0;
      if (duration == '0) begin
        // Zero duration: start and stop on the same visit, never becomes active.
        next_state.remaining = '0;
        next_state.active    = 1'b0;
        startstop            = SS_BOTH;
      end else begin
        next_state.remaining = duration;
        next_state.active    = 1'b1;
        startstop            = SS_START;
      end
    end
  end

endmodule

// File: rtl/ttt_processor_array.sv
// ttt_processor_array: time-multiplexed array of time-to-token processors.
// A round-robin pointer visits one processor per clock; the visit adds the
// token inputs, may fire start/stop events, and the result appears on the
// registered outputs one cycle later. An addressed programming port loads
// thresholds/durations and clears state independently of the sweep.
//   clock_fast        in   sole clock
//   reset             in   asynchronous active-low reset
//   hold              in   freeze sweep and state updates
//   processor_id      out  processor visited this cycle
//   new_good_tokens   in   good tokens for processor_id
//   new_bad_tokens    in   bad tokens for processor_id
//   out_valid         out  registered: a visit completed last cycle
//   out_processor_id  out  registered: processor of the reported event
//   token_startstop   out  registered: {start,stop}
//   sweep_done        out  registered: last processor visited last cycle
//   instruction       in   programming opcode
//   prog_processor_id in   programming target
//   prog_duration     in   duration operand
//   prog_threshold    in   threshold operand
module ttt_processor_array
  import ttt_pkg::*;
#(
  parameter  int NUM_PROCESSORS = 10,
  parameter  int NEW_TOKEN_BITS = 8,
  localparam int TOKEN_BITS     = PKG_TOKEN_BITS,
  localparam int DURATION_BITS  = PKG_DURATION_BITS,
  localparam int PID_W          = $clog2(NUM_PROCESSORS)
) (
  input  logic                      clock_fast,
  input  logic                      reset,
  input  logic                      hold,
  output logic [PID_W-1:0]          processor_id,
  input  logic [NEW_TOKEN_BITS-1:0] new_good_tokens,
  input  logic [NEW_TOKEN_BITS-1:0] new_bad_tokens,
  output logic                      out_valid,
  output logic [PID_W-1:0]          out_processor_id,
  output logic [1:0]                token_startstop,
  output logic                      sweep_done,
  input  logic [2:0]                instruction,
  input  logic [PID_W-1:0]          prog_processor_id,
  input  logic [DURATION_BITS-1:0]  prog_duration,
  input  logic [TOKEN_BITS-1:0]     prog_threshold
);

  localparam logic [PID_W-1:0] LAST_PID = PID_W'(NUM_PROCESSORS - 1);

  logic [PID_W-1:0]         pointer_q, pointer_d;
  proc_state_t              state_q     [NUM_PROCESSORS];
  proc_state_t              state_d     [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0]    threshold_q [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0]    threshold_d [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0] duration_q  [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0] duration_d  [NUM_PROCESSORS];

  logic                     out_valid_q, out_valid_d;
  logic [PID_W-1:0]         out_pid_q, out_pid_d;
  logic [1:0]               startstop_q, startstop_d;
  logic                     sweep_done_q, sweep_done_d;

  proc_state_t              visit_next;
  logic [1:0]               visit_event;
  logic                     prog_valid;
  logic                     clear_hit;

  // Visit always sees pre-write threshold/duration for the same cycle.
  ttt_proc_update #(
    .NEW_TOKEN_BITS (NEW_TOKEN_BITS)
  ) u_update (
    .cur_state       (state_q[pointer_q]),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .threshold       (threshold_q[pointer_q]),
    .duration        (duration_q[pointer_q]),
    .next_state      (visit_next),
    .startstop       (visit_event)
  );

  assign prog_valid = 32'(prog_processor_id) < 32'(NUM_PROCESSORS);

  // A clear that touches the visited processor suppresses the visit's event.
  assign clear_hit = prog_valid &&
                     ((instruction == INSTR_CLEAR_ALL) ||
                      ((instruction == INSTR_CLEAR_STATE) && (prog_processor_id == pointer_q)));

  always_comb begin
    state_d     = state_q;
    threshold_d = threshold_q;
    duration_d  = duration_q;

    if (!hold) begin
      state_d[pointer_q] = visit_next;
    end

    // Programming is applied after the visit so clears override the visit update.
    if (prog_valid) begin
      case (instruction)
        INSTR_LOAD_THRESHOLD: threshold_d[prog_processor_id] = prog_threshold;
        INSTR_LOAD_DURATION:  duration_d[prog_processor_id]  = prog_duration;
        INSTR_CLEAR_STATE:    state_d[prog_processor_id]     = '0;
        INSTR_CLEAR_ALL: begin
          for (int i = 0; i < NUM_PROCESSORS; i++) begin
            state_d[i] = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (hold) begin
      pointer_d = pointer_q;
    end else if (pointer_q == LAST_PID) begin
      pointer_d = '0;
    end else begin
      pointer_d = pointer_q + PID_W'(1);
    end

    out_valid_d  = !hold;
    out_pid_d    = pointer_q;
    startstop_d  = (hold || clear_hit) ? SS_NONE : visit_event;
    sweep_done_d = !hold && (pointer_q == LAST_PID);
  end

  always_ff @(posedge clock_fast or negedge reset) begin
    if (!reset) begin
      pointer_q    <= '0;
      out_valid_q  <= 1'b0;
      out_pid_q    <= '0;
      startstop_q  <= SS_NONE;
      sweep_done_q <= 1'b0;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        state_q[i]     <= '0;
        threshold_q[i] <= '0;
        duration_q[i]  <= '0;
      end
    end else begin
      pointer_q    <= pointer_d;
      out_valid_q  <= out_valid_d;
      out_pid_q    <= out_pid_d;
      startstop_q  <= startstop_d;
      sweep_done_q <= sweep_done_d;
      state_q      <= state_d;
      threshold_q  <= threshold_d;
      duration_q   <= duration_d;
    end
  end

  assign processor_id     = pointer_q;
  assign out_valid        = out_valid_q;
  assign out_processor_id = out_pid_q;
  assign token_startstop  = startstop_q;
  assign sweep_done       = sweep_done_q;

endmodule

// File: tb/tb_ttt_processor_array.sv
module tb_ttt_processor_array;
  import ttt_pkg::*;

  logic       clock_fast = 1'b0;
  logic       reset      = 1'b0;
  logic       hold       = 1'b0;
  logic [3:0] processor_id;
  logic [7:0] new_good_tokens = '0;
  logic [7:0] new_bad_tokens  = '0;
  logic       out_valid;
  logic [3:0] out_processor_id;
  logic [1:0] token_startstop;
  logic       sweep_done;
  logic [2:0] instruction       = '0;
  logic [3:0] prog_processor_id = '0;
  logic [7:0] prog_duration     = '0;
  logic [7:0] prog_threshold    = '0;

  int n_pass  = 0;
  int n_total = 0;

  ttt_processor_array #(
    .NUM_PROCESSORS (10),
    .NEW_TOKEN_BITS (8)
  ) dut (
    .clock_fast        (clock_fast),
    .reset             (reset),
    .hold              (hold),
    .processor_id      (processor_id),
    .new_good_tokens   (new_good_tokens),
    .new_bad_tokens    (new_bad_tokens),
    .out_valid         (out_valid),
    .out_processor_id  (out_processor_id),
    .token_startstop   (token_startstop),
    .sweep_done        (sweep_done),
    .instruction       (instruction),
    .prog_processor_id (prog_processor_id),
    .prog_duration     (prog_duration),
    .prog_threshold    (prog_threshold)
  );

  always #5 clock_fast = ~clock_fast;

  typedef struct {
    logic       hold;
    logic [2:0] instr;
    logic [3:0] tgt;
    logic [7:0] thr;
    logic [7:0] dur;
    logic [7:0] good;
    logic [7:0] bad;
    logic [3:0] exp_cur;
    logic       exp_valid;
    logic [3:0] exp_pid;
    logic [1:0] exp_ss;
    logic       exp_sd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic h, logic [2:0] ins, int t, int thr, int dur, int g, int b,
                              int cur, logic v, int pid, logic [1:0] ss, logic sd);
    vec_t r;
    r.hold = h;  r.instr = ins; r.tgt = 4'(t); r.thr = 8'(thr); r.dur = 8'(dur);
    r.good = 8'(g); r.bad = 8'(b); r.exp_cur = 4'(cur); r.exp_valid = v;
    r.exp_pid = 4'(pid); r.exp_ss = ss; r.exp_sd = sd;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock_fast);
    #1;
  endtask

  task automatic drive(input logic h, input int g, input int b, input logic [2:0] ins,
                       input int t, input int thr, input int dur);
    hold = h; new_good_tokens = 8'(g); new_bad_tokens = 8'(b);
    instruction = ins; prog_processor_id = 4'(t);
    prog_threshold = 8'(thr); prog_duration = 8'(dur);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, INSTR_NOP, 0, 0, 0);
  endtask

  task automatic goto_pid(input int p);
    for (int i = 0; i < 20; i++) begin
      if (int'(processor_id) == p) break;
      step();
    end
    chk("goto_pid", int'(processor_id), p);
  endtask

  task automatic prog(input logic [2:0] ins, input int t, input int thr, input int dur);
    drive(1'b0, 0, 0, ins, t, thr, dur);
    step();
    idle();
  endtask

  task automatic visit(input string name, input int p, input int g, input int b,
                       input logic [2:0] ins, input int t, input int thr, input int dur,
                       input logic [1:0] exp_ss);
    goto_pid(p);
    drive(1'b0, g, b, ins, t, thr, dur);
    step();
    idle();
    $display("visit %s pid=%0d good=%0d bad=%0d -> valid=%0d out_pid=%0d ss=%b",
             name, p, g, b, out_valid, out_processor_id, token_startstop);
    chk({name, " valid"}, int'(out_valid), 1);
    chk({name, " out_pid"}, int'(out_processor_id), p);
    chk({name, " ss"}, int'(token_startstop), int'(exp_ss));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    idle();
    step();
    step();
    chk("rst valid", int'(out_valid), 0);
    chk("rst ss", int'(token_startstop), 0);
    chk("rst sd", int'(sweep_done), 0);
    chk("rst out_pid", int'(out_processor_id), 0);
    chk("rst pid", int'(processor_id), 0);
    reset = 1'b1;

    // Idle sweep: pointer wraps, sweep_done after processor 9
    for (int k = 0; k < 12; k++) begin
      chk("sweep cur", int'(processor_id), k % 10);
      step();
      $display("sweep k=%0d valid=%0d out_pid=%0d ss=%b sd=%0d",
               k, out_valid, out_processor_id, token_startstop, sweep_done);
      chk("sweep valid", int'(out_valid), 1);
      chk("sweep out_pid", int'(out_processor_id), k % 10);
      chk("sweep ss", int'(token_startstop), 0);
      chk("sweep sd", int'(sweep_done), int'(k % 10 == 9));
    end

    // Directed table, starting at pointer 2
    vecs.push_back(mk(0, INSTR_LOAD_THRESHOLD, 3, 5, 0, 0, 0, 2, 1, 2, SS_NONE, 0));
    vecs.push_back(mk(1, INSTR_LOAD_DURATION,  3, 0, 2, 7, 1, 3, 0, 3, SS_NONE, 0));
    vecs.push_back(mk(0, INSTR_NOP,            0, 0, 0, 7, 1, 3, 1, 3, SS_START, 0));
    vecs.push_back(mk(0, INSTR_LOAD_THRESHOLD, 0, 0, 0, 0, 0, 4, 1, 4, SS_NONE, 0));
    for (int p = 5; p <= 9; p++)
      vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 0, 0, p, 1, p, SS_NONE, p == 9));
    vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 1, 0, 0, 1, 0, SS_BOTH, 0));
    for (int p = 1; p <= 2; p++)
      vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 0, 0, p, 1, p, SS_NONE, 0));
    vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 3, 0, 3, 1, 3, SS_NONE, 0));
    for (int p = 4; p <= 9; p++)
      vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 0, 0, p, 1, p, SS_NONE, p == 9));
    vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 4, 4, 0, 1, 0, SS_NONE, 0));
    for (int p = 1; p <= 2; p++)
      vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 0, 0, p, 1, p, SS_NONE, 0));
    vecs.push_back(mk(0, INSTR_NOP, 0, 0, 0, 0, 0, 3, 1, 3, SS_STOP, 0));

    foreach (vecs[i]) begin
      chk($sformatf("row%0d cur", i), int'(processor_id), int'(vecs[i].exp_cur));
      drive(vecs[i].hold, vecs[i].good, vecs[i].bad, vecs[i].instr,
            vecs[i].tgt, vecs[i].thr, vecs[i].dur);
      step();
      idle();
      $display("row %0d hold=%0d pid=%0d good=%0d bad=%0d -> valid=%0d out_pid=%0d ss=%b sd=%0d",
               i, vecs[i].hold, vecs[i].exp_cur, vecs[i].good, vecs[i].bad,
               out_valid, out_processor_id, token_startstop, sweep_done);
      chk($sformatf("row%0d valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("row%0d out_pid", i), int'(out_processor_id), int'(vecs[i].exp_pid));
      chk($sformatf("row%0d ss", i), int'(token_startstop), int'(vecs[i].exp_ss));
      chk($sformatf("row%0d sd", i), int'(sweep_done), int'(vecs[i].exp_sd));
    end

    // Saturation: 200+200 clamps to 255, meeting threshold 255 on the 2nd visit
    prog(INSTR_LOAD_THRESHOLD, 5, 255, 0);
    visit("sat1", 5, 200, 0, INSTR_LOAD_DURATION, 5, 0, 3, SS_NONE);
    visit("sat2", 5, 200, 0, INSTR_NOP, 0, 0, 0, SS_START);

    // Same-cycle threshold load: visit uses the old threshold (0)
    visit("ldthr_old", 8, 1, 0, INSTR_LOAD_THRESHOLD, 8, 50, 0, SS_BOTH);
    visit("ldthr_new", 8, 1, 0, INSTR_NOP, 0, 0, 0, SS_NONE);

    // CLEAR_STATE: conflict with a start-qualified visit, then a plain clear
    prog(INSTR_LOAD_THRESHOLD, 7, 10, 0);
    visit("clr_acc", 7, 5, 0, INSTR_NOP, 0, 0, 0, SS_NONE);
    visit("clr_conf", 7, 20, 0, INSTR_CLEAR_STATE, 7, 0, 0, SS_NONE);
    visit("clr_after", 7, 5, 0, INSTR_NOP, 0, 0, 0, SS_NONE);
    prog(INSTR_CLEAR_STATE, 7, 0, 0);
    visit("clr_plain", 7, 5, 0, INSTR_NOP, 0, 0, 0, SS_NONE);

    // CLEAR_ALL: state wiped, threshold kept
    prog(INSTR_LOAD_THRESHOLD, 6, 10, 0);
    visit("clrall_acc", 6, 5, 0, INSTR_NOP, 0, 0, 0, SS_NONE);
    prog(INSTR_CLEAR_ALL, 0, 0, 0);
    visit("clrall_after", 6, 5, 0, INSTR_NOP, 0, 0, 0, SS_NONE);

    // Re-activate P5 (thr 255, dur 3) for the reset test
    visit("react", 5, 255, 0, INSTR_NOP, 0, 0, 0, SS_START);

    // Hold for 3 cycles at pointer 6
    goto_pid(6);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 9, 0, INSTR_NOP, 0, 0, 0);
      step();
      $display("hold k=%0d pid=%0d valid=%0d sd=%0d", k, processor_id, out_valid, sweep_done);
      chk("hold pid", int'(processor_id), 6);
      chk("hold valid", int'(out_valid), 0);
      chk("hold ss", int'(token_startstop), 0);
    end
    idle();
    step();
    chk("unhold pid", int'(processor_id), 7);
    chk("unhold valid", int'(out_valid), 1);
    chk("unhold out_pid", int'(out_processor_id), 6);

    // Asynchronous reset mid-cycle while P5 is active
    goto_pid(5);
    new_good_tokens = 8'd1;
    #2;
    reset = 1'b0;
    #1;
    $display("async reset pid=%0d valid=%0d ss=%b", processor_id, out_valid, token_startstop);
    chk("areset valid", int'(out_valid), 0);
    chk("areset ss", int'(token_startstop), 0);
    chk("areset out_pid", int'(out_processor_id), 0);
    chk("areset pid", int'(processor_id), 0);
    idle();
    step();
    step();
    reset = 1'b1;
    chk("restart pid", int'(processor_id), 0);
    // Threshold/duration are back to 0, so a single good token gives start+stop
    visit("post_reset", 5, 1, 0, INSTR_NOP, 0, 0, 0, SS_BOTH);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
